// File: rtl/led_strand_pkg.sv
// Shared state type, colour width and counter sizing helper for the strand driver.
package led_strand_pkg;

  typedef enum logic [1:0] {
    RESET_HOLD = 2'd0,
    LOAD       = 2'd1,
    WAIT_COLOR = 2'd2,
    SEND       = 2'd3
  } state_t;

  localparam int COLOR_BITS = 24;
  localparam int BIT_IDX_W  = $clog2(COLOR_BITS);

  // Bits needed to count 0 .. period-1.
  function automatic int counter_width(input int period);
    return (period > 1) ? $clog2(period) : 1;
  endfunction

endpackage

// File: rtl/strand_bit_encoder.sv
// Emits one strand bit per start strobe: high for T0H/T1H cycles, then low
// to the end of a COUNTER_PERIOD-cycle bit slot. Output is registered.
module strand_bit_encoder
  import led_strand_pkg::*;
#(
  parameter int COUNTER_PERIOD = 125,
  parameter int T0H            = 35,
  parameter int T1H            = 70
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic bit_value,
  output logic strand_tx,
  output logic bit_done
);

  localparam int CNT_W = counter_width(COUNTER_PERIOD);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] high_len;
  logic             active;
  logic             bit_reg;

  assign cnt_inc  = cnt + CNT_W'(1);
  assign high_len = bit_reg ? CNT_W'(T1H) : CNT_W'(T0H);
  assign bit_done = active && (cnt == CNT_W'(COUNTER_PERIOD - 1));

  // A start in the final slot cycle chains the next bit with no gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      active    <= 1'b0;
      bit_reg   <= 1'b0;
      strand_tx <= 1'b0;
    end else if (start) begin
      cnt       <= '0;
      active    <= 1'b1;
      bit_reg   <= bit_value;
      strand_tx <= 1'b1;
    end else if (bit_done) begin
      cnt       <= '0;
      active    <= 1'b0;
      strand_tx <= 1'b0;
    end else if (active) begin
      cnt       <= cnt_inc;
      strand_tx <= (cnt_inc < high_len);
    end
  end

endmodule

// File: rtl/led_strand_driver.sv
// WS2812-style strand serialiser: requests colours per LED, sends GRB MSB first,
// inserts the latch gap between frames. Optional LED_STRAND_FRAME_COUNT_EN adds frame_count.
module led_strand_driver
  import led_strand_pkg::*;
#(
  parameter int NUM_LEDS          = 50,
  parameter int LED_ADDRESS_WIDTH = 6,
  parameter int COUNTER_PERIOD    = 125,
  parameter int T0H               = 35,
  parameter int T1H               = 70,
  parameter int RESET_PERIOD      = 5000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   green_in,
  input  logic [7:0]                   red_in,
  input  logic [7:0]                   blue_in,
  input  logic                         color_valid,
  output logic [LED_ADDRESS_WIDTH-1:0] next_led_request,
  output logic                         strand_tx,
  output logic                         frame_done,
  output logic                         underrun
`ifdef LED_STRAND_FRAME_COUNT_EN
  ,
  output logic [15:0]                  frame_count
`endif
);

  localparam int HOLD_W = counter_width(RESET_PERIOD);

  state_t                  state;
  state_t                  state_nxt;
  logic [HOLD_W-1:0]       hold_cnt;
  logic [COLOR_BITS-1:0]   shift_reg;
  logic [BIT_IDX_W-1:0]    bit_idx;
  logic                    last_led;
  logic                    at_last;
  logic                    hold_done;
  logic                    latch;
  logic                    start;
  logic                    bit_value;
  logic                    bit_done;
  logic                    frame_end;
  logic                    underrun_set;

  assign hold_done = (hold_cnt == HOLD_W'(RESET_PERIOD - 1));
  assign at_last   = (next_led_request == LED_ADDRESS_WIDTH'(NUM_LEDS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RESET_HOLD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    latch        = 1'b0;
    start        = 1'b0;
    bit_value    = shift_reg[COLOR_BITS-2];
    frame_end    = 1'b0;
    underrun_set = 1'b0;
    case (state)
      RESET_HOLD: if (hold_done) state_nxt = LOAD;
      LOAD, WAIT_COLOR: begin
        if (color_valid) begin
          latch     = 1'b1;
          start     = 1'b1;
          bit_value = green_in[7];
          state_nxt = SEND;
        end else if (state == LOAD) begin
          underrun_set = 1'b1;
          state_nxt    = WAIT_COLOR;
        end
      end
      SEND: begin
        if (bit_done) begin
          if (bit_idx == BIT_IDX_W'(COLOR_BITS - 1)) begin
            if (last_led) begin
              frame_end = 1'b1;
              state_nxt = RESET_HOLD;
            end else begin
              state_nxt = LOAD;
            end
          end else begin
            start = 1'b1;
          end
        end
      end
      default: state_nxt = RESET_HOLD;
    endcase
  end

  // shift_reg[MSB] is always the bit currently on the wire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt         <= '0;
      shift_reg        <= '0;
      bit_idx          <= '0;
      last_led         <= 1'b0;
      next_led_request <= '0;
      frame_done       <= 1'b0;
      underrun         <= 1'b0;
    end else begin
      frame_done <= frame_end;
      underrun   <= underrun_set;
      hold_cnt   <= (state == RESET_HOLD && !hold_done) ? hold_cnt + HOLD_W'(1) : '0;
      if (latch) begin
        shift_reg        <= {green_in, red_in, blue_in};
        bit_idx          <= '0;
        last_led         <= at_last;
        next_led_request <= at_last ? '0 : next_led_request + LED_ADDRESS_WIDTH'(1);
      end else if (start) begin
        shift_reg <= {shift_reg[COLOR_BITS-2:0], 1'b0};
        bit_idx   <= bit_idx + BIT_IDX_W'(1);
      end
    end
  end

`ifdef LED_STRAND_FRAME_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            frame_count <= '0;
    else if (frame_end) frame_count <= frame_count + 16'd1;
  end
`endif

  strand_bit_encoder #(
    .COUNTER_PERIOD (COUNTER_PERIOD),
    .T0H            (T0H),
    .T1H            (T1H)
  ) u_encoder (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bit_value (bit_value),
    .strand_tx (strand_tx),
    .bit_done  (bit_done)
  );

endmodule

// File: tb/tb_led_strand_driver.sv
// Bench for led_strand_driver: captures the strand cycle by cycle and compares it
// with a waveform built from colour bits and the frame timing rules.
module tb_led_strand_driver;

  localparam int N     = 3;
  localparam int AW    = 2;
  localparam int PER   = 10;
  localparam int T0    = 3;
  localparam int T1    = 7;
  localparam int RP    = 40;
  localparam int CB    = 24;
  localparam int STALL = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    green_in, red_in, blue_in;
  logic          color_valid;
  logic [AW-1:0] next_led_request;
  logic          strand_tx, frame_done, underrun;
`ifdef LED_STRAND_FRAME_COUNT_EN
  logic [15:0]   frame_count;
`endif

  logic [23:0] colors [4];
  logic        valid_drv = 1'b1;
  int          extra [N];
  int          total = 0;
  int          bad = 0;
  bit          cap_en = 1'b0;

  bit tx_q[$];
  bit fd_q[$];
  bit un_q[$];
  int req_q[$];
  int fc_q[$];
  bit exp_q[$];
  int fd_exp[$];
  int fd_act[$];

  always #5 clk = ~clk;

  assign green_in    = colors[next_led_request][23:16];
  assign red_in      = colors[next_led_request][15:8];
  assign blue_in     = colors[next_led_request][7:0];
  assign color_valid = valid_drv;

  led_strand_driver #(
    .NUM_LEDS(N), .LED_ADDRESS_WIDTH(AW), .COUNTER_PERIOD(PER),
    .T0H(T0), .T1H(T1), .RESET_PERIOD(RP)
  ) dut (
    .clk(clk), .rst(rst),
    .green_in(green_in), .red_in(red_in), .blue_in(blue_in),
    .color_valid(color_valid),
    .next_led_request(next_led_request),
    .strand_tx(strand_tx), .frame_done(frame_done), .underrun(underrun)
`ifdef LED_STRAND_FRAME_COUNT_EN
    , .frame_count(frame_count)
`endif
  );

  always @(negedge clk) begin
    if (cap_en) begin
      tx_q.push_back(strand_tx);
      fd_q.push_back(frame_done);
      un_q.push_back(underrun);
      req_q.push_back(int'(next_led_request));
`ifdef LED_STRAND_FRAME_COUNT_EN
      fc_q.push_back(int'(frame_count));
`endif
    end
  end

  // ---------------- reference model ----------------
  task automatic push_n(input bit v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  // Sample 0 is the first full cycle after rst falls; the cycle rst falls in
  // already counts as the first hold cycle, so RP-1 hold samples remain.
  task automatic build_expected(input int nframes);
    exp_q.delete();
    fd_exp.delete();
    push_n(1'b0, RP - 1);
    for (int f = 0; f < nframes; f++) begin
      for (int led = 0; led < N; led++) begin
        push_n(1'b0, 1 + ((f == 0) ? extra[led] : 0));
        for (int b = CB - 1; b >= 0; b--) begin
          int th;
          th = colors[led][b] ? T1 : T0;
          push_n(1'b1, th);
          push_n(1'b0, PER - th);
        end
      end
      fd_exp.push_back(exp_q.size());
      push_n(1'b0, RP);
    end
    push_n(1'b0, 1);
    push_n(1'b1, 1);
  endtask

  // ---------------- analysis helpers ----------------
  task automatic wave_diff(output int nerr, output int first);
    nerr = 0;
    first = -1;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i >= tx_q.size() || tx_q[i] != exp_q[i]) begin
        nerr++;
        if (first < 0) first = i;
      end
    end
  endtask

  task automatic collect_fd();
    fd_act.delete();
    for (int i = 0; i < fd_q.size(); i++) if (fd_q[i]) fd_act.push_back(i);
  endtask

  function automatic string req_seq_str(input int upto);
    string s;
    int prev;
    s = "";
    prev = -1;
    for (int i = 0; i < upto && i < req_q.size(); i++) begin
      if (req_q[i] != prev) begin
        s = {s, $sformatf("%0d,", req_q[i])};
        prev = req_q[i];
      end
    end
    return s;
  endfunction

  function automatic string exp_req_str();
    string s;
    s = "";
    for (int i = 0; i < N; i++) s = {s, $sformatf("%0d,", i)};
    return {s, "0,"};
  endfunction

  task automatic random_colors();
    for (int i = 0; i < 4; i++) colors[i] = 24'($urandom());
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    tx_q.delete(); fd_q.delete(); un_q.delete(); req_q.delete(); fc_q.delete();
    cap_en = 1'b1;
  endtask

  task automatic do_reset();
    cap_en = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    release_reset();
  endtask

  task automatic wait_capture(input string name);
    int g;
    g = 0;
    while (tx_q.size() < exp_q.size() && g < exp_q.size() + 1000) begin
      @(posedge clk);
      g++;
    end
    if (tx_q.size() < exp_q.size()) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: captured %0d cycles, required %0d", name, tx_q.size(), exp_q.size());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (strand_tx !== 1'b0) begin bad++; $display("FAIL reset_tx: got %0b want 0", strand_tx); end
    total++; if (next_led_request !== '0) begin bad++; $display("FAIL reset_req: got %0d want 0", next_led_request); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done: got %0b want 0", frame_done); end
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL reset_underrun: got %0b want 0", underrun); end
`ifdef LED_STRAND_FRAME_COUNT_EN
    total++; if (frame_count !== 16'd0) begin bad++; $display("FAIL reset_frame_count: got %0d want 0", frame_count); end
`endif
  endtask

  task automatic test_fixed_pattern();
    int nerr, first, first_req, nun, rise;
    int runs[$];
    int exp_runs[24];
    int run_err;
    exp_runs = '{7,3,7,3,3,7,3,7, 3,3,3,3,3,3,3,3, 7,7,7,7,7,7,7,7};
    for (int i = 0; i < 4; i++) colors[i] = 24'hA500FF;
    for (int i = 0; i < N; i++) extra[i] = 0;
    do_reset();
    build_expected(1);
    wait_capture("fixed");
    wave_diff(nerr, first);
    total++;
    if (nerr !== 0) begin
      bad++;
      $display("FAIL fixed_wave: %0d cycles differ, first at %0d (got %0b want %0b)",
               nerr, first, (first < tx_q.size()) ? tx_q[first] : 1'b0, exp_q[first]);
    end
    rise = 0;
    for (int i = 0; i < tx_q.size(); i++) begin
      if (tx_q[i]) rise++;
      else if (rise != 0) begin runs.push_back(rise); rise = 0; end
    end
    run_err = 0;
    for (int k = 0; k < 24; k++) if (k >= runs.size() || runs[k] != exp_runs[k]) run_err++;
    total++;
    if (run_err !== 0) begin bad++; $display("FAIL fixed_pulses: %0d of 24 LED0 high pulses wrong (pulses seen %0d)", run_err, runs.size()); end
    collect_fd();
    total++;
    if (fd_act.size() !== 1 || fd_act[0] !== fd_exp[0]) begin
      bad++;
      $display("FAIL fixed_frame_done: got %0d pulses first at %0d, want 1 at %0d",
               fd_act.size(), (fd_act.size() > 0) ? fd_act[0] : -1, fd_exp[0]);
    end
    total++;
    if (req_seq_str(fd_exp[0]) != exp_req_str()) begin
      bad++; $display("FAIL fixed_req_seq: got %s want %s", req_seq_str(fd_exp[0]), exp_req_str());
    end
    first_req = -1;
    for (int i = 0; i < req_q.size(); i++) if (first_req < 0 && req_q[i] != 0) first_req = i;
    total++;
    if (first_req !== RP) begin bad++; $display("FAIL fixed_req_update: got cycle %0d want %0d", first_req, RP); end
    nun = 0;
    foreach (un_q[i]) if (un_q[i]) nun++;
    total++;
    if (nun !== 0) begin bad++; $display("FAIL fixed_underrun: got %0d pulses want 0", nun); end
  endtask

  task automatic test_random_frames();
    int nerr, first;
    for (int i = 0; i < N; i++) extra[i] = 0;
    for (int r = 0; r < 3; r++) begin
      random_colors();
      do_reset();
      build_expected(1);
      wait_capture("random");
      wave_diff(nerr, first);
      total++;
      if (nerr !== 0) begin
        bad++;
        $display("FAIL random_wave[%0d]: %0d cycles differ, first at %0d (got %0b want %0b)",
                 r, nerr, first, (first < tx_q.size()) ? tx_q[first] : 1'b0, exp_q[first]);
      end
      total++;
      if (req_seq_str(fd_exp[0]) != exp_req_str()) begin
        bad++; $display("FAIL random_req_seq[%0d]: got %s want %s", r, req_seq_str(fd_exp[0]), exp_req_str());
      end
    end
  endtask

  task automatic test_underrun();
    int nerr, first, g, nun, un_idx, exp_un;
    random_colors();
    for (int i = 0; i < N; i++) extra[i] = 0;
    extra[1] = STALL;
    do_reset();
    build_expected(1);
    g = 0;
    do begin @(negedge clk); g++; end while (next_led_request != AW'(1) && g < 2000);
    valid_drv = 1'b0;
    repeat (CB * PER + STALL) @(negedge clk);
    valid_drv = 1'b1;
    wait_capture("underrun");
    wave_diff(nerr, first);
    total++;
    if (nerr !== 0) begin
      bad++;
      $display("FAIL underrun_wave: %0d cycles differ, first at %0d (got %0b want %0b)",
               nerr, first, (first < tx_q.size()) ? tx_q[first] : 1'b0, exp_q[first]);
    end
    nun = 0;
    un_idx = -1;
    foreach (un_q[i]) if (un_q[i]) begin nun++; if (un_idx < 0) un_idx = i; end
    exp_un = (RP - 1) + (1 + CB * PER) + 1;
    total++;
    if (nun !== 1) begin bad++; $display("FAIL underrun_count: got %0d want 1", nun); end
    total++;
    if (un_idx !== exp_un) begin bad++; $display("FAIL underrun_time: got cycle %0d want %0d", un_idx, exp_un); end
    collect_fd();
    total++;
    if (fd_act.size() !== 1 || fd_act[0] !== fd_exp[0]) begin
      bad++;
      $display("FAIL underrun_frame_done: got %0d pulses first at %0d, want 1 at %0d",
               fd_act.size(), (fd_act.size() > 0) ? fd_act[0] : -1, fd_exp[0]);
    end
    extra[1] = 0;
  endtask

  task automatic test_reset_mid_frame();
    int nerr, first, g, stop_idx;
    random_colors();
    for (int i = 0; i < N; i++) extra[i] = 0;
    do_reset();
    stop_idx = (RP - 1) + (CB * PER + 1) + 1 + 12 * PER + 2;
    g = 0;
    while (tx_q.size() < stop_idx && g < 2000) begin @(posedge clk); g++; end
    #2;
    total++;
    if (strand_tx !== 1'b1) begin bad++; $display("FAIL midreset_pre_tx: got %0b want 1", strand_tx); end
    cap_en = 1'b0;
    rst = 1'b1;
    #1;
    total++;
    if (strand_tx !== 1'b0) begin bad++; $display("FAIL midreset_tx: got %0b want 0", strand_tx); end
    total++;
    if (next_led_request !== '0) begin bad++; $display("FAIL midreset_req: got %0d want 0", next_led_request); end
    repeat (2) @(negedge clk);
    release_reset();
    build_expected(1);
    wait_capture("midreset");
    wave_diff(nerr, first);
    total++;
    if (nerr !== 0) begin
      bad++;
      $display("FAIL midreset_wave: %0d cycles differ, first at %0d (got %0b want %0b)",
               nerr, first, (first < tx_q.size()) ? tx_q[first] : 1'b0, exp_q[first]);
    end
  endtask

  task automatic test_back_to_back();
    int nerr, first;
    random_colors();
    for (int i = 0; i < N; i++) extra[i] = 0;
    do_reset();
    build_expected(3);
    wait_capture("b2b");
    wave_diff(nerr, first);
    total++;
    if (nerr !== 0) begin
      bad++;
      $display("FAIL b2b_wave: %0d cycles differ, first at %0d (got %0b want %0b)",
               nerr, first, (first < tx_q.size()) ? tx_q[first] : 1'b0, exp_q[first]);
    end
    collect_fd();
    total++;
    if (fd_act.size() !== 3) begin bad++; $display("FAIL b2b_frame_done_count: got %0d want 3", fd_act.size()); end
    for (int k = 0; k < 3 && k < fd_act.size(); k++) begin
      total++;
      if (fd_act[k] !== fd_exp[k]) begin bad++; $display("FAIL b2b_frame_done_time[%0d]: got %0d want %0d", k, fd_act[k], fd_exp[k]); end
`ifdef LED_STRAND_FRAME_COUNT_EN
      total++;
      if (fc_q[fd_act[k]] !== k + 1) begin bad++; $display("FAIL frame_count[%0d]: got %0d want %0d", k, fc_q[fd_act[k]], k + 1); end
`endif
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) colors[i] = 24'h0;
    for (int i = 0; i < N; i++) extra[i] = 0;
    test_reset();
    test_fixed_pattern();
    test_random_frames();
    test_underrun();
    test_reset_mid_frame();
    test_back_to_back();
    cap_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
